// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Active-high {g,f,e,d,c,b,a} patterns, entry 15 first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

    function automatic logic inactive_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-high segment pattern; pin polarity is applied by the parent.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with frame-boundary commit of loaded words.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int   CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INACT = inactive_level(ACTIVE_LOW);

    scan_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        slot_end, frame_end;

    logic [NUM_DIGITS-1:0][3:0]  disp_word, pend_word;
    logic [NUM_DIGITS-1:0]       disp_mask, pend_mask;
    logic                        pend_full;

    logic [NUM_DIGITS-1:0][6:0]  seg_dec;
    logic [NUM_DIGITS-1:0]       blank;
    logic [6:0]                  seg_d;
    logic [NUM_DIGITS-1:0]       dig_d;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_hex_decoder u_dec (
            .nibble (disp_word[i]),
            .seg    (seg_dec[i])
        );
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Digit 0 is never leading-zero blanked so an all-zero word still shows "0".
    always_comb begin
        logic seen;
        seen     = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen        = seen | (disp_word[i] != 4'h0);
            lz_blank[i] = ~seen;
        end
    end

    assign blank = disp_mask | lz_blank;
`else
    assign blank = disp_mask;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        slot_end  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        seg_d     = {7{INACT}};
        dig_d     = {NUM_DIGITS{INACT}};

        case (state_q)
            GUARD:   if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) state_d = DRIVE;
            DRIVE:   if (slot_end) state_d = GUARD;
            default: state_d = GUARD;
        endcase

        if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end

        // Output registers capture this cycle's state, so pins lag the FSM by one clock.
        if (state_q == DRIVE) begin
            dig_d = (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{ACTIVE_LOW}};
            if (!blank[idx_q]) seg_d = seg_dec[idx_q] ^ {7{ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_word <= '0;
            disp_mask <= '1;
            pend_word <= '0;
            pend_mask <= '0;
            pend_full <= 1'b0;
            seg_out   <= {7{INACT}};
            dig_sel   <= {NUM_DIGITS{INACT}};
        end else begin
            seg_out <= seg_d;
            dig_sel <= dig_d;
            // Commit and accept are exclusive: commit needs pending full, accept needs it empty.
            if (frame_end && pend_full) begin
                disp_word <= pend_word;
                disp_mask <= pend_mask;
                pend_full <= 1'b0;
            end else if (load_valid && !pend_full) begin
                pend_word <= load_data;
                pend_mask <= blank_mask;
                pend_full <= 1'b1;
            end
        end
    end

    assign load_ready = ~pend_full;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2-cycle guard.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int GC = 2;
    localparam int FR = ND * SC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        load_ready, frame_done;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        load_ready_al, frame_done_al;
    logic [6:0]  seg_out_al;
    logic [3:0]  dig_sel_al;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] cap_dig [0:2*FR-1];
    logic [6:0] cap_seg [0:2*FR-1];
    logic [6:0] cap_pre_seg;
    int         acc_j;
    logic [6:0] exp_seg [0:7];

    seg7_scan_driver #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .GUARD_CYCLES(GC), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_mask(blank_mask), .seg_out(seg_out),
        .dig_sel(dig_sel), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .GUARD_CYCLES(GC), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_al),
        .load_data(load_data), .blank_mask(blank_mask), .seg_out(seg_out_al),
        .dig_sel(dig_sel_al), .frame_done(frame_done_al)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_frame_done: no frame_done within 80 cycles");
        end
    endtask

    task automatic do_load(input logic [15:0] data, input logic [3:0] mask);
        bit ok;
        ok = 1'b0;
        load_data  = data;
        blank_mask = mask;
        load_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (load_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        load_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL load_accept: load_ready never seen for %h", data);
        end
    endtask

    // Call on the frame_done sample; records nf following frames, p=0 is digit 0 first guard cycle.
    task automatic capture(input int nf);
        bit acc;
        acc_j = -1;
        acc = load_valid && load_ready;
        tick();
        if (acc) begin load_valid = 1'b0; acc_j = 0; end
        cap_pre_seg = seg_out;
        for (int p = 0; p < nf * FR; p++) begin
            acc = load_valid && load_ready;
            tick();
            if (acc) begin load_valid = 1'b0; acc_j = p + 1; end
            cap_dig[p] = dig_sel;
            cap_seg[p] = seg_out;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_chk++;
        if (seg_out !== 7'h00 || dig_sel !== 4'h0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: seg=%h dig=%b rdy=%b fd=%b expected 00 0000 1 0",
                     seg_out, dig_sel, load_ready, frame_done);
        end
        n_chk++;
        if (seg_out_al !== 7'h7F || dig_sel_al !== 4'hF || load_ready_al !== 1'b1 || frame_done_al !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_al: seg=%h dig=%b rdy=%b fd=%b expected 7f 1111 1 0",
                     seg_out_al, dig_sel_al, load_ready_al, frame_done_al);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int n, d;
        logic [3:0] ed;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (frame_done) begin n = k; break; end
        end
        n_chk++;
        if (n != FR - 1) begin
            n_fail++;
            $display("FAIL first_frame_done: cycle %0d expected %0d", n, FR - 1);
        end
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (frame_done) begin n = k; break; end
        end
        n_chk++;
        if (n != FR) begin
            n_fail++;
            $display("FAIL frame_period: %0d expected %0d", n, FR);
        end
        capture(1);
        for (int p = 0; p < FR; p++) begin
            d  = p / SC;
            ed = ((p % SC) < GC) ? 4'h0 : 4'(1 << d);
            n_chk++;
            if (cap_dig[p] !== ed || cap_seg[p] !== 7'h00) begin
                n_fail++;
                $display("FAIL scan_idle p=%0d dig=%b seg=%h expected dig=%b seg=00", p, cap_dig[p], cap_seg[p], ed);
            end
        end
    endtask

    task automatic test_load_midframe();
        int d;
        logic [3:0] ed;
        logic [6:0] es;
        repeat (10) tick();
        do_load(16'h1A3F, 4'h0);
        n_chk++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: load_ready=%b expected 0", load_ready);
        end
        wait_fd();
        n_chk++;
        if (load_ready !== 1'b0 || seg_out !== 7'h00) begin
            n_fail++;
            $display("FAIL old_frame_kept: rdy=%b seg=%h expected 0 00", load_ready, seg_out);
        end
        exp_seg[0] = 7'h71; exp_seg[1] = 7'h4F; exp_seg[2] = 7'h77; exp_seg[3] = 7'h06;
        capture(1);
        n_chk++;
        if (cap_pre_seg !== 7'h00) begin
            n_fail++;
            $display("FAIL old_frame_tail: seg=%h expected 00", cap_pre_seg);
        end
        for (int p = 0; p < FR; p++) begin
            d  = p / SC;
            ed = ((p % SC) < GC) ? 4'h0 : 4'(1 << d);
            es = ((p % SC) < GC) ? 7'h00 : exp_seg[d];
            n_chk++;
            if (cap_dig[p] !== ed || cap_seg[p] !== es) begin
                n_fail++;
                $display("FAIL load_1a3f p=%0d dig=%b seg=%h expected dig=%b seg=%h", p, cap_dig[p], cap_seg[p], ed, es);
            end
        end
        n_chk++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_rise: load_ready=%b expected 1", load_ready);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [3:0] ed;
        logic [6:0] es;
        do_load(16'h1111, 4'h0);
        load_data  = 16'h2222;
        blank_mask = 4'h0;
        load_valid = 1'b1;
        wait_fd();
        n_chk++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL second_stalled: load_ready=%b expected 0", load_ready);
        end
        for (int i = 0; i < 4; i++) begin
            exp_seg[i]     = 7'h06;
            exp_seg[i + 4] = 7'h5B;
        end
        capture(2);
        n_chk++;
        if (acc_j != 1) begin
            n_fail++;
            $display("FAIL second_accept_cycle: %0d expected 1", acc_j);
        end
        for (int p = 0; p < 2 * FR; p++) begin
            d  = (p / SC) % ND;
            ed = ((p % SC) < GC) ? 4'h0 : 4'(1 << d);
            es = ((p % SC) < GC) ? 7'h00 : exp_seg[p / SC];
            n_chk++;
            if (cap_dig[p] !== ed || cap_seg[p] !== es) begin
                n_fail++;
                $display("FAIL back_to_back p=%0d dig=%b seg=%h expected dig=%b seg=%h", p, cap_dig[p], cap_seg[p], ed, es);
            end
        end
    endtask

    task automatic test_blank_mask();
        int d;
        logic [3:0] ed;
        logic [6:0] es;
        do_load(16'h8888, 4'b0101);
        wait_fd();
        exp_seg[0] = 7'h00; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h00; exp_seg[3] = 7'h7F;
        capture(1);
        for (int p = 0; p < FR; p++) begin
            d  = p / SC;
            ed = ((p % SC) < GC) ? 4'h0 : 4'(1 << d);
            es = ((p % SC) < GC) ? 7'h00 : exp_seg[d];
            n_chk++;
            if (cap_dig[p] !== ed || cap_seg[p] !== es) begin
                n_fail++;
                $display("FAIL blank_mask p=%0d dig=%b seg=%h expected dig=%b seg=%h", p, cap_dig[p], cap_seg[p], ed, es);
            end
        end
    endtask

    task automatic test_leading_zero();
        int d;
        logic [3:0] ed;
        logic [6:0] es;
        for (int w = 0; w < 2; w++) begin
            do_load((w == 0) ? 16'h0020 : 16'h0000, 4'h0);
            wait_fd();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            exp_seg[0] = 7'h3F; exp_seg[1] = (w == 0) ? 7'h5B : 7'h00; exp_seg[2] = 7'h00; exp_seg[3] = 7'h00;
`else
            exp_seg[0] = 7'h3F; exp_seg[1] = (w == 0) ? 7'h5B : 7'h3F; exp_seg[2] = 7'h3F; exp_seg[3] = 7'h3F;
`endif
            capture(1);
            for (int p = 0; p < FR; p++) begin
                d  = p / SC;
                ed = ((p % SC) < GC) ? 4'h0 : 4'(1 << d);
                es = ((p % SC) < GC) ? 7'h00 : exp_seg[d];
                n_chk++;
                if (cap_dig[p] !== ed || cap_seg[p] !== es) begin
                    n_fail++;
                    $display("FAIL leading_zero w=%0d p=%0d dig=%b seg=%h expected dig=%b seg=%h",
                             w, p, cap_dig[p], cap_seg[p], ed, es);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n;
        logic [6:0] e2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        e2 = 7'h00;
`else
        e2 = 7'h3F;
`endif
        wait_fd();
        do_load(16'h5555, 4'h0);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dig_sel === 4'b0100) begin ok = 1'b1; break; end
            tick();
        end
        n_chk++;
        if (!ok || load_ready !== 1'b0 || seg_out !== e2) begin
            n_fail++;
            $display("FAIL reach_digit2: found=%b rdy=%b seg=%h expected 1 0 %h", ok, load_ready, seg_out, e2);
        end
        n_chk++;
        if (dig_sel_al !== 4'b1011 || seg_out_al !== ~e2) begin
            n_fail++;
            $display("FAIL active_low_drive: dig=%b seg=%h expected 1011 %h", dig_sel_al, seg_out_al, ~e2);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (seg_out !== 7'h00 || dig_sel !== 4'h0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: seg=%h dig=%b rdy=%b fd=%b expected 00 0000 1 0",
                     seg_out, dig_sel, load_ready, frame_done);
        end
        n_chk++;
        if (seg_out_al !== 7'h7F || dig_sel_al !== 4'hF || load_ready_al !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_al: seg=%h dig=%b rdy=%b expected 7f 1111 1", seg_out_al, dig_sel_al, load_ready_al);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_chk++;
        if (dig_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL restart_guard: dig=%b expected 0000", dig_sel);
        end
        tick();
        n_chk++;
        if (dig_sel !== 4'b0001 || seg_out !== 7'h00 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_digit0: dig=%b seg=%h rdy=%b expected 0001 00 1", dig_sel, seg_out, load_ready);
        end
        n = 3;
        for (int k = 0; k < 40 && !frame_done; k++) begin
            tick();
            n++;
        end
        n_chk++;
        if (n != FR - 1) begin
            n_fail++;
            $display("FAIL restart_frame_done: cycle %0d expected %0d", n, FR - 1);
        end
        capture(1);
        for (int p = 0; p < FR; p++) begin
            n_chk++;
            if (cap_seg[p] !== 7'h00) begin
                n_fail++;
                $display("FAIL pending_discarded p=%0d seg=%h expected 00", p, cap_seg[p]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_back_to_back();
        test_blank_mask();
        test_leading_zero();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
